alu_sweep_ctrl: RTL and testbench
=================================

ALU_SWEEP_CTRL -- requirements
Module: alu_sweep_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 start  input  1  begin sweep; sampled only in IDLE.
REQ-004 op_a, op_b  input  8 each  operands latched at start.
REQ-005 hold  input  4  extra settle cycles per code (H), latched at start.
REQ-006 alu_a, alu_b  output  8 each  operands driven to the ALU.
REQ-007 alu_cin  output  1  carry-in driven to the ALU.
REQ-008 alu_sel  output  4  operation select driven to the ALU.
REQ-009 alu_y  input  8  ALU result.
REQ-010 rec_valid / rec_ready  output / input  1 each  result-record handshake.
REQ-011 rec_sel  output  4  code of the current record; rec_y  output  8  captured result.
REQ-012 busy  output  1  sweep in progress; done  output  1  one-cycle end-of-sweep pulse.
REQ-013 sig  output  16  result signature; present only with ALU_SWEEP_SIG_EN.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, SEND, DONE.
REQ-015 IDLE with start=1 SHALL do the following: latch op_a→alu_a, op_b→alu_b, hold→H; set alu_sel=0, alu_cin=0, counter=H; go to SETTLE.
REQ-016 SETTLE with counter≠0 SHALL decrement the counter; with counter=0 it SHALL capture alu_y→rec_y and alu_sel→rec_sel, set rec_valid=1, and go to SEND.
REQ-017 rec_valid SHALL first rise H+1 edges after the start edge; a record SHALL take H+2 cycles when rec_ready=1.
REQ-018 In SEND, rec_valid, rec_sel, rec_y and all alu_* outputs SHALL stay stable until the edge where rec_valid&rec_ready=1.
REQ-019 On acceptance with alu_sel<15: alu_sel increments, alu_cin=1 iff new alu_sel=5, counter=H, go to SETTLE; rec_valid=0.
REQ-020 On acceptance with alu_sel=15: rec_valid=0, go to DONE; DONE asserts done for one cycle, then goes to IDLE.
REQ-021 busy SHALL be 1 in SETTLE and SEND, and 0 in IDLE and DONE.
REQ-022 start SHALL be ignored outside IDLE; start held high through DONE SHALL begin a new sweep from the following IDLE cycle.
REQ-023 A full sweep with rec_ready=1 SHALL assert done 16*(H+2) edges after the start edge.
REQ-024 alu_a, alu_b, alu_sel and alu_cin SHALL hold their last values in IDLE and DONE.

Reset
REQ-025 When rst_n=0, the state SHALL go to IDLE immediately, and these outputs SHALL be 0: alu_a, alu_b, alu_cin, alu_sel, rec_valid, rec_sel, rec_y, busy, done, sig.
REQ-026 Reset mid-sweep SHALL abandon the sweep; the next start SHALL begin at alu_sel=0.

Configuration
REQ-027 With ALU_SWEEP_SIG_EN defined:
- sig SHALL clear to 0 on the start edge.
- On each accepted record, sig SHALL update to rotl1(sig) ^ {rec_sel, 4'h0, rec_y}.
REQ-028 Without ALU_SWEEP_SIG_EN, port sig and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-029 Basic sweep: op_a=0x93, op_b=0xA7, H=2, rec_ready=1, start pulse → 16 records, rec_sel 0..15, each rec_y = alu_y at capture, alu_cin=1 only while alu_sel=5, done 64 cycles after start.
REQ-030 Backpressure: rec_ready=0 for 5 cycles while rec_sel=3 → rec_valid, rec_sel=3, rec_y and alu_sel=3 stable throughout; sweep resumes with sel 4.
REQ-031 H=0, rec_ready=1 → a record every 2 cycles; done 32 cycles after start; start pulses while busy=1 are ignored.
REQ-032 Reset: rst_n=0 while alu_sel=7 → all outputs 0 asynchronously; after release, start → first record rec_sel=0.
REQ-033 Signature (macro on): alu_y stub tied to 0x00, full sweep → sig=0x708F at done; a second sweep → sig cleared, then 0x708F again.

Source files
------------

// File: rtl/alu_sweep_ctrl_if.sv
// ALU drive bus plus result-record channel shared by the sweep controller
// (master) and the ALU/record sink side (slave).
interface alu_sweep_ctrl_if;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_cin;
    logic [3:0] alu_sel;
    logic [7:0] alu_y;
    logic       rec_valid;
    logic       rec_ready;
    logic [3:0] rec_sel;
    logic [7:0] rec_y;

    modport master (
        output alu_a, alu_b, alu_cin, alu_sel, rec_valid, rec_sel, rec_y,
        input  alu_y, rec_ready
    );

    modport slave (
        input  alu_a, alu_b, alu_cin, alu_sel, rec_valid, rec_sel, rec_y,
        output alu_y, rec_ready
    );
endinterface

// File: rtl/alu_sweep_ctrl.sv
// ALU sweep controller: steps alu_sel through all 16 codes with fixed
// operands, waits H settle cycles per code, then hands the captured result
// out as a valid/ready record. Optional 16-bit result signature is built
// when ALU_SWEEP_SIG_EN is defined; without it the sig port does not exist.
module alu_sweep_ctrl (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [7:0]              op_a,
    input  logic [7:0]              op_b,
    input  logic [3:0]              hold,
    alu_sweep_ctrl_if.master        bus,
`ifdef ALU_SWEEP_SIG_EN
    output logic [15:0]             sig,
`endif
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, SETTLE, SEND, DONE} state_t;

    state_t     state;
    logic [3:0] h_q;   // settle cycles per code, latched at start
    logic [3:0] cnt;   // remaining settle cycles for the current code

    // Sweep FSM; every output is registered here so it is glitch-free at the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            h_q           <= 4'd0;
            cnt           <= 4'd0;
            bus.alu_a     <= 8'd0;
            bus.alu_b     <= 8'd0;
            bus.alu_cin   <= 1'b0;
            bus.alu_sel   <= 4'd0;
            bus.rec_valid <= 1'b0;
            bus.rec_sel   <= 4'd0;
            bus.rec_y     <= 8'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef ALU_SWEEP_SIG_EN
            sig           <= 16'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bus.alu_a   <= op_a;
                        bus.alu_b   <= op_b;
                        bus.alu_sel <= 4'd0;
                        bus.alu_cin <= 1'b0;
                        h_q         <= hold;
                        cnt         <= hold;
                        busy        <= 1'b1;
                        state       <= SETTLE;
`ifdef ALU_SWEEP_SIG_EN
                        sig         <= 16'd0;
`endif
                    end
                end
                SETTLE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        bus.rec_y     <= bus.alu_y;
                        bus.rec_sel   <= bus.alu_sel;
                        bus.rec_valid <= 1'b1;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    // rec_valid is known high here, so ready alone completes the handshake
                    if (bus.rec_ready) begin
                        bus.rec_valid <= 1'b0;
`ifdef ALU_SWEEP_SIG_EN
                        sig <= {sig[14:0], sig[15]} ^ {bus.rec_sel, 4'h0, bus.rec_y};
`endif
                        if (bus.alu_sel == 4'd15) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            bus.alu_sel <= bus.alu_sel + 4'd1;
                            // carry-in is exercised only on code 5
                            bus.alu_cin <= (bus.alu_sel == 4'd4);
                            cnt         <= h_q;
                            state       <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not sampled here; it is seen next cycle in IDLE
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Bench for alu_sweep_ctrl: sweep-timeline reference model with per-cycle
// compare, plus hand-computed literal expectations for records, latency and
// signature.
module tb_alu_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] op_a = 8'd0;
    logic [7:0] op_b = 8'd0;
    logic [3:0] hold = 4'd0;
    logic       busy;
    logic       done;
`ifdef ALU_SWEEP_SIG_EN
    logic [15:0] sig;
`endif
    logic       stub_zero = 1'b0;

    int total = 0;
    int bad = 0;

    alu_sweep_ctrl_if bus();

    always #5 clk = ~clk;

    alu_sweep_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .hold  (hold),
        .bus   (bus),
`ifdef ALU_SWEEP_SIG_EN
        .sig   (sig),
`endif
        .busy  (busy),
        .done  (done)
    );

    // ALU stub: distinct result per code, carry-in visible in the sum
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin, input logic [3:0] sel,
                                          input logic z);
        logic [7:0] s;
        s = a + b + {7'd0, cin};
        return z ? 8'h00 : (s ^ {sel, sel});
    endfunction

    assign bus.alu_y = alu_fn(bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_sel, stub_zero);

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: sweep as a timeline of edge numbers
    longint     ecount = 0;
    longint     valid_edge = -1;
    logic       m_busy = 0, m_done = 0, m_valid = 0, m_cin = 0;
    logic [3:0] m_sel = 0, m_recsel = 0, m_h = 0;
    logic [7:0] m_a = 0, m_b = 0, m_recy = 0;
    logic [15:0] m_sig = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_done <= 0; m_valid <= 0; m_cin <= 0;
            m_sel <= 0; m_recsel <= 0; m_h <= 0;
            m_a <= 0; m_b <= 0; m_recy <= 0; m_sig <= 0;
            valid_edge <= -1;
        end else begin
            ecount <= ecount + 1;
            m_done <= 0;
            if (m_done) begin
                // end-of-sweep cycle: start not honoured
            end else if (!m_busy) begin
                if (start) begin
                    m_busy <= 1; m_a <= op_a; m_b <= op_b; m_h <= hold;
                    m_sel <= 0; m_cin <= 0; m_sig <= 0;
                    valid_edge <= ecount + 2 + longint'(hold);
                end
            end else if (m_valid) begin
                if (bus.rec_ready) begin
                    m_valid <= 0;
                    m_sig <= {m_sig[14:0], m_sig[15]} ^ {m_recsel, 4'h0, m_recy};
                    if (m_sel == 4'd15) begin
                        m_busy <= 0; m_done <= 1;
                    end else begin
                        m_sel <= m_sel + 4'd1;
                        m_cin <= ((m_sel + 4'd1) == 4'd5);
                        valid_edge <= ecount + 2 + longint'(m_h);
                    end
                end
            end else if (ecount + 1 == valid_edge) begin
                m_valid <= 1; m_recsel <= m_sel;
                m_recy <= alu_fn(m_a, m_b, m_cin, m_sel, stub_zero);
            end
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", {15'd0, busy}, {15'd0, m_busy});
            chk("done", {15'd0, done}, {15'd0, m_done});
            chk("rec_valid", {15'd0, bus.rec_valid}, {15'd0, m_valid});
            chk("rec_sel", {12'd0, bus.rec_sel}, {12'd0, m_recsel});
            chk("rec_y", {8'd0, bus.rec_y}, {8'd0, m_recy});
            chk("alu_sel", {12'd0, bus.alu_sel}, {12'd0, m_sel});
            chk("alu_cin", {15'd0, bus.alu_cin}, {15'd0, m_cin});
            chk("alu_a", {8'd0, bus.alu_a}, {8'd0, m_a});
            chk("alu_b", {8'd0, bus.alu_b}, {8'd0, m_b});
`ifdef ALU_SWEEP_SIG_EN
            chk("sig", sig, m_sig);
`endif
        end
    end

    // accepted-record log for literal checks
    logic [3:0] log_sel [256];
    logic [7:0] log_y   [256];
    int         log_n = 0;

    always @(posedge clk) begin
        if (rst_n && bus.rec_valid && bus.rec_ready) begin
            if (log_n < 256) begin
                log_sel[log_n] <= bus.rec_sel;
                log_y[log_n]   <= bus.rec_y;
            end
            log_n <= log_n + 1;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // lat = edges from the start edge to the edge that raised done
    task automatic run_until_done(input int limit, output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (lat >= limit) begin
                total++; bad++;
                $display("FAIL done_timeout act=none exp=done_within_%0d", limit);
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_alu_a"}, {8'd0, bus.alu_a}, 16'd0);
        chk({nm, "_alu_b"}, {8'd0, bus.alu_b}, 16'd0);
        chk({nm, "_alu_cin"}, {15'd0, bus.alu_cin}, 16'd0);
        chk({nm, "_alu_sel"}, {12'd0, bus.alu_sel}, 16'd0);
        chk({nm, "_rec_valid"}, {15'd0, bus.rec_valid}, 16'd0);
        chk({nm, "_rec_sel"}, {12'd0, bus.rec_sel}, 16'd0);
        chk({nm, "_rec_y"}, {8'd0, bus.rec_y}, 16'd0);
        chk({nm, "_busy"}, {15'd0, busy}, 16'd0);
        chk({nm, "_done"}, {15'd0, done}, 16'd0);
`ifdef ALU_SWEEP_SIG_EN
        chk({nm, "_sig"}, sig, 16'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        bit found;
        bus.rec_ready = 1'b1;

        // reset state
        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic sweep, H=2
        op_a = 8'h93; op_b = 8'hA7; hold = 4'd2;
        base = log_n;
        pulse_start();
        run_until_done(300, lat);
        chk("basic_lat", lat[15:0], 16'd64);
        chk("basic_nrec", 16'(log_n - base), 16'd16);
        chk("basic_rec0_y", {8'd0, log_y[base]}, 16'h003A);
        chk("basic_rec5_y", {8'd0, log_y[base+5]}, 16'h006E);
        chk("basic_rec15_y", {8'd0, log_y[base+15]}, 16'h00C5);
        for (int i = 0; i < 16; i++)
            chk("basic_sel_seq", {12'd0, log_sel[base+i]}, 16'(i));
        @(posedge clk); #1;

        // backpressure on code 3, H=1
        op_a = 8'h12; op_b = 8'h34; hold = 4'd1;
        base = log_n;
        pulse_start();
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.rec_valid && bus.rec_sel == 4'd3) begin found = 1; break; end
        end
        chk("bp_reach_sel3", {15'd0, found}, 16'd1);
        bus.rec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            chk("bp_valid_hold", {15'd0, bus.rec_valid}, 16'd1);
            chk("bp_alu_sel_hold", {12'd0, bus.alu_sel}, 16'd3);
            chk("bp_rec_y_hold", {8'd0, bus.rec_y}, 16'h0046 ^ 16'h0033);
        end
        bus.rec_ready = 1'b1;
        run_until_done(300, lat);
        chk("bp_nrec", 16'(log_n - base), 16'd16);
        chk("bp_rec3_sel", {12'd0, log_sel[base+3]}, 16'd3);
        chk("bp_rec4_sel", {12'd0, log_sel[base+4]}, 16'd4);
        @(posedge clk); #1;

        // H=0 with start held high through the sweep and the DONE cycle
        op_a = 8'h5A; op_b = 8'hC3; hold = 4'd0;
        start = 1'b1;
        @(posedge clk); #1;
        run_until_done(200, lat);
        chk("h0_lat", lat[15:0], 16'd32);
        @(posedge clk);
        @(negedge clk);
        chk("h0_idle_after_done", {15'd0, busy}, 16'd0);
        @(posedge clk); #1;
        start = 1'b0;
        run_until_done(200, lat);
        chk("h0_restart_lat", lat[15:0], 16'd32);
        @(posedge clk); #1;

        // asynchronous reset while alu_sel=7
        op_a = 8'h01; op_b = 8'h02; hold = 4'd1;
        pulse_start();
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.alu_sel == 4'd7) begin found = 1; break; end
        end
        chk("rst_reach_sel7", {15'd0, found}, 16'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        base = log_n;
        pulse_start();
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (log_n > base) begin found = 1; break; end
        end
        chk("rst_first_rec_seen", {15'd0, found}, 16'd1);
        chk("rst_first_rec_sel", {12'd0, log_sel[base]}, 16'd0);
        run_until_done(200, lat);
        @(posedge clk); #1;

`ifdef ALU_SWEEP_SIG_EN
        // signature with a zero ALU, two back-to-back sweeps
        stub_zero = 1'b1;
        hold = 4'd0;
        pulse_start();
        run_until_done(200, lat);
        chk("sig_sweep1", sig, 16'h708F);
        @(posedge clk); #1;
        pulse_start();
        chk("sig_cleared", sig, 16'h0000);
        run_until_done(200, lat);
        chk("sig_sweep2", sig, 16'h708F);
        @(posedge clk); #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
